// File: rtl/sop_controller.sv
// sop_controller: sequences coefficient loading, sample streaming and result
// capture for an external sum-of-products datapath with PIPE_LAT latency.
module sop_controller #(
   parameter int DATA_WIDTH = 4,
   parameter int PIPE_LAT   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [1:0]                cfg_addr,
   input  logic [DATA_WIDTH-1:0]     cfg_data,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      in_ready,
   output logic [DATA_WIDTH-1:0]     sop_data_in,
   output logic [DATA_WIDTH-1:0]     coef11,
   output logic [DATA_WIDTH-1:0]     coef12,
   output logic [DATA_WIDTH-1:0]     coef21,
   output logic [DATA_WIDTH-1:0]     coef22,
   input  logic [2*DATA_WIDTH+1:0]   sop_sum,
   output logic                      out_valid,
   output logic [2*DATA_WIDTH+1:0]   out_sum,
   output logic                      busy,
   output logic                      cfg_err,
   output logic [15:0]               out_cnt
);

   localparam int CNT_W = $clog2(PIPE_LAT + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        mask;
   logic [CNT_W-1:0]  flush_cnt;
   logic [PIPE_LAT:0] vld_p;
   logic              accept;
   logic              run_entry;
   logic              start_fault;
   logic              cfg_wr;
   logic              cfg_err_nxt;

   assign in_ready    = (state == ST_RUN) & ~stop;
   assign busy        = (state != ST_IDLE);
   assign accept      = in_valid & in_ready;
   assign cfg_wr      = cfg_we & (state == ST_IDLE);
   assign cfg_err_nxt = start_fault | (cfg_we & busy);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; a start without a full coefficient set is a fault
   always_comb begin
      state_nxt   = state;
      start_fault = 1'b0;
      run_entry   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (mask == 4'hF) begin
                  state_nxt = ST_RUN;
                  run_entry = 1'b1;
               end else begin
                  start_fault = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (stop) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (flush_cnt == CNT_W'(PIPE_LAT)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Flush timer: runs PIPE_LAT+1 cycles so every in-flight token drains
   always_ff @(posedge clk) begin
      if (rst || state != ST_FLUSH) flush_cnt <= '0;
      else                          flush_cnt <= flush_cnt + CNT_W'(1);
   end

   // Coefficient bank and loaded mask, writable only while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         coef11 <= '0;
         coef12 <= '0;
         coef21 <= '0;
         coef22 <= '0;
         mask   <= 4'h0;
      end else if (cfg_wr) begin
         case (cfg_addr)
            2'd0:    coef11 <= cfg_data;
            2'd1:    coef12 <= cfg_data;
            2'd2:    coef21 <= cfg_data;
            default: coef22 <= cfg_data;
         endcase
         mask <= mask | (4'b0001 << cfg_addr);
      end
   end

   // Stage p0: sample feed, bubbles are zero so idle slots contribute nothing
   always_ff @(posedge clk) begin
      if (rst) sop_data_in <= '0;
      else     sop_data_in <= accept ? in_data : '0;
   end

   // Token pipe tracking which datapath slots carry a real sample
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i <= PIPE_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Result capture when a token reaches the end of the datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cnt   <= 16'd0;
      end else begin
         out_valid <= vld_p[PIPE_LAT];
         if (vld_p[PIPE_LAT]) out_sum <= sop_sum;
         if (run_entry)             out_cnt <= 16'd0;
         else if (vld_p[PIPE_LAT])  out_cnt <= out_cnt + 16'd1;
      end
   end

   // Configuration error pulse
   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= cfg_err_nxt;
   end

endmodule

// File: tb/tb_sop_controller.sv
// Bench for sop_controller: behavioural datapath plus queue-based result model.
module tb_sop_controller;

   localparam int DW = 4;
   localparam int PL = 2;
   localparam int SW = 2*DW + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_addr = 2'd0;
   logic [DW-1:0] cfg_data = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic [DW-1:0] sop_data_in, coef11, coef12, coef21, coef22;
   logic [SW-1:0] sop_sum = '0;
   logic          out_valid;
   logic [SW-1:0] out_sum;
   logic          busy, cfg_err;
   logic [15:0]   out_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   sop_controller #(.DATA_WIDTH(DW), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .sop_data_in(sop_data_in),
      .coef11(coef11), .coef12(coef12), .coef21(coef21), .coef22(coef22),
      .sop_sum(sop_sum), .out_valid(out_valid), .out_sum(out_sum),
      .busy(busy), .cfg_err(cfg_err), .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   // External datapath: two register stages, sum of the four coefficient products
   logic [DW-1:0] dp_x = '0;
   always @(posedge clk) begin
      dp_x    <= sop_data_in;
      sop_sum <= SW'(coef11) * SW'(dp_x) + SW'(coef12) * SW'(dp_x)
               + SW'(coef21) * SW'(dp_x) + SW'(coef22) * SW'(dp_x);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
         if (n_fail >= 100) begin
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
         end
      end
   endtask

   // Reference model: mode, coefficients and a queue of scheduled results
   int            edge_n = 0;
   int            m_mode = 0;   // 0 idle, 1 run, 2 flush
   int            m_left = 0;
   logic [3:0]    m_mask = 4'h0;
   logic [DW-1:0] m_coef [4];
   int            q_due [$];
   logic [SW-1:0] q_sum [$];
   logic          m_valid = 1'b0;
   logic [SW-1:0] m_sum = '0;
   logic [15:0]   m_cnt = 16'd0;
   logic          m_err = 1'b0;
   logic [DW-1:0] m_sdi = '0;

   function automatic logic [SW-1:0] model_sum(input logic [DW-1:0] x);
      int s;
      s = (int'(m_coef[0]) + int'(m_coef[1]) + int'(m_coef[2]) + int'(m_coef[3])) * int'(x);
      return SW'(s);
   endfunction

   always @(posedge clk) begin
      edge_n++;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_sdi   = '0;
      if (rst) begin
         m_mode = 0;
         m_left = 0;
         m_mask = 4'h0;
         for (int k = 0; k < 4; k++) m_coef[k] = '0;
         q_due.delete();
         q_sum.delete();
         m_sum = '0;
         m_cnt = 16'd0;
      end else begin
         if (q_due.size() > 0 && q_due[0] == edge_n) begin
            m_valid = 1'b1;
            m_sum   = q_sum[0];
            void'(q_due.pop_front());
            void'(q_sum.pop_front());
            m_cnt   = m_cnt + 16'd1;
         end
         if (m_mode == 0) begin
            if (start) begin
               if (m_mask == 4'hF) begin
                  m_mode = 1;
                  m_cnt  = 16'd0;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (cfg_we) begin
               m_coef[cfg_addr] = cfg_data;
               m_mask[cfg_addr] = 1'b1;
            end
         end else if (m_mode == 1) begin
            if (cfg_we) m_err = 1'b1;
            if (stop) begin
               m_mode = 2;
               m_left = PL + 1;
            end else if (in_valid) begin
               q_due.push_back(edge_n + PL + 1);
               q_sum.push_back(model_sum(in_data));
               m_sdi = in_data;
            end
         end else begin
            if (cfg_we) m_err = 1'b1;
            m_left--;
            if (m_left == 0) m_mode = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("out_valid",   32'(out_valid),   32'(m_valid));
         chk("out_sum",     32'(out_sum),     32'(m_sum));
         chk("out_cnt",     32'(out_cnt),     32'(m_cnt));
         chk("busy",        32'(busy),        32'(m_mode != 0));
         chk("in_ready",    32'(in_ready),    32'(m_mode == 1 && !stop));
         chk("cfg_err",     32'(cfg_err),     32'(m_err));
         chk("sop_data_in", 32'(sop_data_in), 32'(m_sdi));
         chk("coef11",      32'(coef11),      32'(m_coef[0]));
         chk("coef12",      32'(coef12),      32'(m_coef[1]));
         chk("coef21",      32'(coef21),      32'(m_coef[2]));
         chk("coef22",      32'(coef22),      32'(m_coef[3]));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [DW-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   // Watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] burst [4];
      burst[0] = 4'd1; burst[1] = 4'd2; burst[2] = 4'd3; burst[3] = 4'd7;

      step(); step();
      chk_en = 1'b1;
      chk("rst_busy",     32'(busy), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_cnt",  32'(out_cnt), 0);
      chk("rst_out_sum",  32'(out_sum), 0);
      rst = 1'b0;

      // Incomplete coefficient set: start rejected
      cfg_write(2'd0, 4'd1);
      cfg_write(2'd1, 4'd2);
      cfg_write(2'd2, 4'd3);
      pulse_start();
      chk("partial_cfg_err", 32'(cfg_err), 1);
      chk("partial_busy",    32'(busy), 0);
      step();
      chk("partial_err_end", 32'(cfg_err), 0);
      chk("partial_idle",    32'(busy), 0);

      // Full set: run starts
      cfg_write(2'd3, 4'd4);
      pulse_start();
      chk("run_busy",     32'(busy), 1);
      chk("run_in_ready", 32'(in_ready), 1);
      chk("run_coefs",    {16'd0, coef11, coef12, coef21, coef22}, 32'h1234);
      chk("run_out_cnt",  32'(out_cnt), 0);

      // Single accept, latency PIPE_LAT+1
      in_valid = 1'b1; in_data = 4'd5;
      step();
      in_valid = 1'b0;
      chk("lat_sdi",   32'(sop_data_in), 5);
      chk("lat_e0",    32'(out_valid), 0);
      step();
      chk("lat_e1",    32'(out_valid), 0);
      step();
      chk("lat_e2",    32'(out_valid), 0);
      step();
      chk("lat_e3",    32'(out_valid), 1);
      chk("lat_sum",   32'(out_sum), 50);
      chk("lat_cnt",   32'(out_cnt), 1);
      step();
      chk("lat_pulse", 32'(out_valid), 0);
      chk("lat_hold",  32'(out_sum), 50);

      // start ignored in RUN; cfg write rejected in RUN
      pulse_start();
      chk("start_in_run", 32'(cfg_err), 0);
      cfg_write(2'd1, 4'd9);
      chk("run_cfg_err",  32'(cfg_err), 1);
      chk("run_coef12",   32'(coef12), 2);

      // Stop and flush
      pulse_stop();
      chk("flush_busy",   32'(busy), 1);
      step(); step();
      chk("flush_last",   32'(busy), 1);
      step();
      chk("flush_done",   32'(busy), 0);

      // stop in IDLE ignored
      pulse_stop();
      chk("stop_idle",    32'(busy), 0);

      // Burst of four then stop with a sample that must be refused
      pulse_start();
      chk("burst_cnt0",   32'(out_cnt), 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = burst[i];
         step();
      end
      in_data = 4'd15; stop = 1'b1;
      step();
      in_valid = 1'b0; stop = 1'b0;
      step(); step(); step();
      chk("burst_out_cnt", 32'(out_cnt), 4);
      chk("burst_last",    32'(out_sum), 70);
      chk("burst_idle",    32'(busy), 0);
      chk("burst_ready",   32'(in_ready), 0);

      // Reset with results in flight
      pulse_start();
      in_valid = 1'b1; in_data = 4'd3;
      step();
      in_data = 4'd6;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstf_valid",  32'(out_valid), 0);
      chk("rstf_sum",    32'(out_sum), 0);
      chk("rstf_cnt",    32'(out_cnt), 0);
      chk("rstf_coef",   {16'd0, coef11, coef12, coef21, coef22}, 0);
      chk("rstf_busy",   32'(busy), 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rstf_novalid", 32'(out_valid), 0);
      end

      // out_cnt wrap after 65536 results
      cfg_write(2'd0, 4'd1);
      cfg_write(2'd1, 4'd1);
      cfg_write(2'd2, 4'd1);
      cfg_write(2'd3, 4'd1);
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_data = DW'(i);
         step();
      end
      in_valid = 1'b0;
      pulse_stop();
      step();
      chk("wrap_ffff",  32'(out_cnt), 32'h0000_FFFF);
      step();
      chk("wrap_zero",  32'(out_cnt), 0);
      chk("wrap_valid", 32'(out_valid), 1);
      chk("wrap_sum",   32'(out_sum), 60);
      step();
      chk("wrap_idle",  32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
